// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter_pkg
//  Description : Shared types and constants for the two-port RAM arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_port_arbiter_pkg;

    // These default widths are shared with the cache and RAM.
    localparam int c_DEF_AW = 10;
    localparam int c_DEF_DW = 20;

    localparam logic c_OWN_R0 = 1'b0;
    localparam logic c_OWN_R1 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OWN    = 2'd1,
        ST_RDWAIT = 2'd2
    } arb_state_t;

    function automatic logic [1:0] owner_onehot(input logic owner);
        return (owner == c_OWN_R1) ? 2'b10 : 2'b01;
    endfunction

endpackage : mem_port_arbiter_pkg
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter_if
//  Description : Requester handshakes, RAM port and grant bundle.
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW = c_DEF_AW,
    parameter int DW = c_DEF_DW
) ();

    logic          r0_req;
    logic          r0_rw;
    logic [AW-1:0] r0_addr;
    logic [DW-1:0] r0_wdata;
    logic          r0_ready;
    logic [DW-1:0] r0_rdata;

    logic          r1_req;
    logic          r1_rw;
    logic [AW-1:0] r1_addr;
    logic [DW-1:0] r1_wdata;
    logic          r1_ready;
    logic [DW-1:0] r1_rdata;

    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    logic [1:0]    gnt;

    // Requesters and the RAM sit on this side.
    modport master (
        output r0_req, r0_rw, r0_addr, r0_wdata,
        input  r0_ready, r0_rdata,
        output r1_req, r1_rw, r1_addr, r1_wdata,
        input  r1_ready, r1_rdata,
        input  ram_we, ram_addr, ram_wdata,
        output ram_rdata,
        input  gnt
    );

    // The arbiter sits on this side.
    modport slave (
        input  r0_req, r0_rw, r0_addr, r0_wdata,
        output r0_ready, r0_rdata,
        input  r1_req, r1_rw, r1_addr, r1_wdata,
        output r1_ready, r1_rdata,
        output ram_we, ram_addr, ram_wdata,
        input  ram_rdata,
        output gnt
    );

endinterface : mem_port_arbiter_if
`default_nettype wire

// File: rtl/mem_port_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick2
//  Description : Combinational two-way round-robin picker, one-hot result.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_pick2 (
    input  wire logic [1:0] i_req,
    input  wire logic       i_ptr,
    output logic      [1:0] o_win
);

    always_comb begin
        o_win = i_req;
        // On a tie the pointer names the winner.
        if (i_req == 2'b11) begin
            o_win = i_ptr ? 2'b10 : 2'b01;
        end
    end

endmodule : rr_pick2
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Two-requester arbiter for one single-port word RAM.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW        = c_DEF_AW,
    parameter int DW        = c_DEF_DW,
    parameter int READ_LAT  = 0,
    parameter int MAX_BEATS = 8
) (
    input  wire logic         clk,
    input  wire logic         rst,
    mem_port_arbiter_if.slave bus
);

    localparam int              c_CW      = $clog2(MAX_BEATS + 1);
    localparam logic [c_CW-1:0] c_MAX_CNT = c_CW'(MAX_BEATS);

    arb_state_t      r_state;
    arb_state_t      w_state_nxt;
    logic            r_owner;
    logic            w_owner_nxt;
    logic            r_rr_ptr;
    logic            w_rr_ptr_nxt;
    logic [c_CW-1:0] r_beat_cnt;
    logic [c_CW-1:0] w_beat_cnt_nxt;
    logic [c_CW-1:0] w_beat_cnt_inc;

    logic            w_own_req;
    logic            w_own_rw;
    logic [AW-1:0]   w_own_addr;
    logic [DW-1:0]   w_own_wdata;
    logic            w_other_req;
    logic [1:0]      w_win;

    logic [1:0]      w_gnt;
    logic            w_ram_we;
    logic [AW-1:0]   w_ram_addr;
    logic [DW-1:0]   w_ram_wdata;
    logic            w_ready_own;
    logic            w_ready_ok;
    logic [DW-1:0]   w_rdata_own;
    logic            w_beat_done;

    assign w_own_req   = (r_owner == c_OWN_R1) ? bus.r1_req   : bus.r0_req;
    assign w_own_rw    = (r_owner == c_OWN_R1) ? bus.r1_rw    : bus.r0_rw;
    assign w_own_addr  = (r_owner == c_OWN_R1) ? bus.r1_addr  : bus.r0_addr;
    assign w_own_wdata = (r_owner == c_OWN_R1) ? bus.r1_wdata : bus.r0_wdata;
    assign w_other_req = (r_owner == c_OWN_R1) ? bus.r0_req   : bus.r1_req;

    assign w_beat_cnt_inc = (r_beat_cnt == c_MAX_CNT) ? r_beat_cnt
                                                      : r_beat_cnt + 1'b1;

    rr_pick2 u_pick (
        .i_req ({bus.r1_req, bus.r0_req}),
        .i_ptr (r_rr_ptr),
        .o_win (w_win)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_owner    <= c_OWN_R0;
            r_rr_ptr   <= 1'b0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_owner_nxt    = r_owner;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_beat_cnt_nxt = r_beat_cnt;
        w_gnt          = 2'b00;
        w_ram_we       = 1'b0;
        w_ram_addr     = '0;
        w_ram_wdata    = '0;
        w_ready_own    = 1'b0;
        w_rdata_own    = '0;
        w_beat_done    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (|w_win) begin
                    w_owner_nxt    = w_win[1];
                    w_beat_cnt_nxt = '0;
                    w_state_nxt    = ST_OWN;
                end
            end

            ST_OWN: begin
                w_gnt       = owner_onehot(r_owner);
                w_ram_addr  = w_own_addr;
                w_ram_wdata = w_own_wdata;
                w_ram_we    = w_own_req & w_own_rw;
                if (!w_own_req) begin
                    w_state_nxt    = ST_IDLE;
                    w_rr_ptr_nxt   = ~r_owner;
                    w_beat_cnt_nxt = '0;
                end else if (w_own_rw || (READ_LAT == 0)) begin
                    w_ready_own = 1'b1;
                    w_rdata_own = w_own_rw ? '0 : bus.ram_rdata;
                    w_beat_done = 1'b1;
                end else begin
                    w_state_nxt = ST_RDWAIT;
                end
            end

            // The read completes even if the owner dropped req meanwhile.
            ST_RDWAIT: begin
                w_gnt       = owner_onehot(r_owner);
                w_ram_addr  = w_own_addr;
                w_ready_own = 1'b1;
                w_rdata_own = bus.ram_rdata;
                w_beat_done = 1'b1;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Fairness guard: a saturated owner yields once the other side waits.
        if (w_beat_done) begin
            w_beat_cnt_nxt = w_beat_cnt_inc;
            w_state_nxt    = ST_OWN;
            if ((w_beat_cnt_inc == c_MAX_CNT) && w_other_req) begin
                w_state_nxt    = ST_IDLE;
                w_rr_ptr_nxt   = ~r_owner;
                w_beat_cnt_nxt = '0;
            end
        end
    end

    // A beat caught by reset is abandoned: no ready, no write.
    assign w_ready_ok    = w_ready_own & rst;

    assign bus.r0_ready  = w_ready_ok & (r_owner == c_OWN_R0);
    assign bus.r0_rdata  = (w_ready_ok && (r_owner == c_OWN_R0)) ? w_rdata_own : '0;
    assign bus.r1_ready  = w_ready_ok & (r_owner == c_OWN_R1);
    assign bus.r1_rdata  = (w_ready_ok && (r_owner == c_OWN_R1)) ? w_rdata_own : '0;

    assign bus.ram_we    = w_ram_we & rst;
    assign bus.ram_addr  = w_ram_addr;
    assign bus.ram_wdata = w_ram_wdata;
    assign bus.gnt       = w_gnt;

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Scoreboard bench for mem_port_arbiter (READ_LAT 0 and 1).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int c_AW = 10;
    localparam int c_DW = 20;

    typedef struct packed {
        logic            rw;
        logic [c_AW-1:0] addr;
        logic [c_DW-1:0] data;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(c_AW), .DW(c_DW)) bus0 ();
    mem_port_arbiter_if #(.AW(c_AW), .DW(c_DW)) bus1 ();

    mem_port_arbiter #(.AW(c_AW), .DW(c_DW), .READ_LAT(0), .MAX_BEATS(8)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    mem_port_arbiter #(.AW(c_AW), .DW(c_DW), .READ_LAT(1), .MAX_BEATS(8)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    // RAM models: combinational read for dut0, registered read for dut1.
    logic [c_DW-1:0] r_mem0 [0:1023];
    logic [c_DW-1:0] r_mem1 [0:1023];
    logic [c_DW-1:0] r_rd1;

    always @(posedge clk) begin
        if (bus0.ram_we) r_mem0[bus0.ram_addr] <= bus0.ram_wdata;
    end
    assign bus0.ram_rdata = r_mem0[bus0.ram_addr];

    always @(posedge clk) begin
        if (bus1.ram_we) r_mem1[bus1.ram_addr] <= bus1.ram_wdata;
        r_rd1 <= r_mem1[bus1.ram_addr];
    end
    assign bus1.ram_rdata = r_rd1;

    beat_t           q0[$];
    beat_t           q1[$];
    beat_t           e0[$];
    beat_t           e1[$];
    int              ready_log[$];
    logic [c_DW-1:0] shadow [0:1023];
    int              total = 0;
    int              bad   = 0;

    task automatic clear_inputs();
        bus0.r0_req = 1'b0; bus0.r0_rw = 1'b0; bus0.r0_addr = '0; bus0.r0_wdata = '0;
        bus0.r1_req = 1'b0; bus0.r1_rw = 1'b0; bus0.r1_addr = '0; bus0.r1_wdata = '0;
        bus1.r0_req = 1'b0; bus1.r0_rw = 1'b0; bus1.r0_addr = '0; bus1.r0_wdata = '0;
        bus1.r1_req = 1'b0; bus1.r1_rw = 1'b0; bus1.r1_addr = '0; bus1.r1_wdata = '0;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Queue a beat for a dut0 requester and record what it must return.
    task automatic queue_beat(input int who, input logic rw,
                              input logic [c_AW-1:0] addr, input logic [c_DW-1:0] wdata);
        beat_t b;
        beat_t e;
        b.rw = rw; b.addr = addr; b.data = wdata;
        e = b;
        if (rw) shadow[addr] = wdata;
        else    e.data = shadow[addr];
        if (who == 0) begin q0.push_back(b); e0.push_back(e); end
        else          begin q1.push_back(b); e1.push_back(e); end
    endtask

    task automatic drive_heads();
        bus0.r0_req = 1'b0; bus0.r1_req = 1'b0;
        if (q0.size() > 0) begin
            bus0.r0_req = 1'b1; bus0.r0_rw = q0[0].rw;
            bus0.r0_addr = q0[0].addr; bus0.r0_wdata = q0[0].data;
        end
        if (q1.size() > 0) begin
            bus0.r1_req = 1'b1; bus0.r1_rw = q1[0].rw;
            bus0.r1_addr = q1[0].addr; bus0.r1_wdata = q1[0].data;
        end
    endtask

    function automatic string log_str(input int q[$]);
        string s = "";
        foreach (q[i]) s = {s, $sformatf("%0d", q[i])};
        return s;
    endfunction

    function automatic bit logs_equal(input int a[$], input int b[$]);
        if (a.size() != b.size()) return 1'b0;
        foreach (a[i]) if (a[i] != b[i]) return 1'b0;
        return 1'b1;
    endfunction

    // Runs queued dut0 traffic; each ready pops the scoreboard and is checked.
    task automatic run_traffic(input int max_cycles);
        beat_t e;
        ready_log.delete();
        for (int cyc = 0; cyc < max_cycles && (q0.size() > 0 || q1.size() > 0); cyc++) begin
            @(posedge clk); #1;
            drive_heads();
            @(negedge clk);
            if (bus0.r0_ready && bus0.r1_ready) begin
                total++; bad++;
                $display("FAIL dual_ready: both readies high, gnt=%b required one owner", bus0.gnt);
            end
            if (bus0.r0_ready) begin
                ready_log.push_back(0);
                total++;
                if (e0.size() == 0) begin
                    bad++;
                    $display("FAIL r0_spurious_ready: ready=1 required 0 (no pending beat)");
                end else begin
                    e = e0.pop_front();
                    void'(q0.pop_front());
                    if (e.rw) begin
                        if ({bus0.gnt, bus0.ram_we, bus0.ram_addr, bus0.ram_wdata} !== {2'b01, 1'b1, e.addr, e.data}) begin
                            bad++;
                            $display("FAIL r0_write_beat: gnt=%b we=%b addr=%h wdata=%0d required gnt=01 we=1 addr=%h wdata=%0d",
                                     bus0.gnt, bus0.ram_we, bus0.ram_addr, bus0.ram_wdata, e.addr, e.data);
                        end
                    end else if ({bus0.gnt, bus0.r0_rdata} !== {2'b01, e.data}) begin
                        bad++;
                        $display("FAIL r0_read_beat: gnt=%b rdata=%0d required gnt=01 rdata=%0d",
                                 bus0.gnt, bus0.r0_rdata, e.data);
                    end
                end
            end
            if (bus0.r1_ready) begin
                ready_log.push_back(1);
                total++;
                if (e1.size() == 0) begin
                    bad++;
                    $display("FAIL r1_spurious_ready: ready=1 required 0 (no pending beat)");
                end else begin
                    e = e1.pop_front();
                    void'(q1.pop_front());
                    if (e.rw) begin
                        if ({bus0.gnt, bus0.ram_we, bus0.ram_addr, bus0.ram_wdata} !== {2'b10, 1'b1, e.addr, e.data}) begin
                            bad++;
                            $display("FAIL r1_write_beat: gnt=%b we=%b addr=%h wdata=%0d required gnt=10 we=1 addr=%h wdata=%0d",
                                     bus0.gnt, bus0.ram_we, bus0.ram_addr, bus0.ram_wdata, e.addr, e.data);
                        end
                    end else if ({bus0.gnt, bus0.r1_rdata} !== {2'b10, e.data}) begin
                        bad++;
                        $display("FAIL r1_read_beat: gnt=%b rdata=%0d required gnt=10 rdata=%0d",
                                 bus0.gnt, bus0.r1_rdata, e.data);
                    end
                end
            end
        end
        @(posedge clk); #1;
        drive_heads();
        if (q0.size() > 0 || q1.size() > 0) begin
            total++; bad++;
            $display("FAIL traffic_timeout: pending r0=%0d r1=%0d required 0 0", q0.size(), q1.size());
            q0.delete(); q1.delete(); e0.delete(); e1.delete();
            drive_heads();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        total++;
        if ({bus0.gnt, bus0.ram_we, bus0.ram_addr, bus0.ram_wdata, bus0.r0_ready, bus0.r0_rdata,
             bus0.r1_ready, bus0.r1_rdata} !== '0) begin
            bad++;
            $display("FAIL reset_dut0: gnt=%b we=%b addr=%h wdata=%h rdy=%b%b required all 0",
                     bus0.gnt, bus0.ram_we, bus0.ram_addr, bus0.ram_wdata, bus0.r0_ready, bus0.r1_ready);
        end
        total++;
        if ({bus1.gnt, bus1.ram_we, bus1.ram_addr, bus1.ram_wdata, bus1.r0_ready, bus1.r0_rdata,
             bus1.r1_ready, bus1.r1_rdata} !== '0) begin
            bad++;
            $display("FAIL reset_dut1: gnt=%b we=%b addr=%h wdata=%h rdy=%b%b required all 0",
                     bus1.gnt, bus1.ram_we, bus1.ram_addr, bus1.ram_wdata, bus1.r0_ready, bus1.r1_ready);
        end
        @(posedge clk); #1 rst = 1'b1;
    endtask

    task automatic test_single_write();
        @(posedge clk); #1;
        bus0.r0_req = 1'b1; bus0.r0_rw = 1'b1; bus0.r0_addr = 10'h032; bus0.r0_wdata = 20'd300;
        @(negedge clk);
        total++;
        if ({bus0.gnt, bus0.r0_ready} !== 3'b000) begin
            bad++;
            $display("FAIL idle_latency: gnt=%b ready=%b required gnt=00 ready=0", bus0.gnt, bus0.r0_ready);
        end
        @(negedge clk);
        total++;
        if ({bus0.gnt, bus0.r0_ready, bus0.ram_we, bus0.ram_addr, bus0.ram_wdata} !==
            {2'b01, 1'b1, 1'b1, 10'h032, 20'd300}) begin
            bad++;
            $display("FAIL single_write: gnt=%b ready=%b we=%b addr=%h wdata=%0d required 01 1 1 032 300",
                     bus0.gnt, bus0.r0_ready, bus0.ram_we, bus0.ram_addr, bus0.ram_wdata);
        end
        @(posedge clk); #1;
        bus0.r0_req = 1'b0;
        shadow[10'h032] = 20'd300;
        @(negedge clk);
        total++;
        if (r_mem0[10'h032] !== 20'd300) begin
            bad++;
            $display("FAIL single_write_ram: RAM[032]=%0d required 300", r_mem0[10'h032]);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_tie_release();
        int exp_log[$];
        apply_reset();
        queue_beat(0, 1'b1, 10'h020, 20'd11);
        queue_beat(1, 1'b1, 10'h021, 20'd22);
        ready_log.delete();
        // Cycle-exact grant trace: IDLE, r0 beat, r0 release, one IDLE, r1 beat.
        begin
            logic [1:0] gl[$];
            logic [1:0] ge[$];
            ge = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10};
            for (int c = 0; c < 5; c++) begin
                @(posedge clk); #1;
                drive_heads();
                @(negedge clk);
                gl.push_back(bus0.gnt);
                if (bus0.r0_ready) begin ready_log.push_back(0); void'(q0.pop_front()); void'(e0.pop_front()); end
                if (bus0.r1_ready) begin ready_log.push_back(1); void'(q1.pop_front()); void'(e1.pop_front()); end
            end
            total++;
            if (gl !== ge) begin
                bad++;
                $display("FAIL tie_gnt_trace: %b %b %b %b %b required 00 01 01 00 10",
                         gl[0], gl[1], gl[2], gl[3], gl[4]);
            end
        end
        exp_log = '{0, 1};
        total++;
        if (!logs_equal(ready_log, exp_log)) begin
            bad++;
            $display("FAIL tie_order: ready order %s required %s", log_str(ready_log), log_str(exp_log));
        end
        q0.delete(); q1.delete(); e0.delete(); e1.delete();
        drive_heads();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_burst_lock();
        int exp_log[$];
        apply_reset();
        queue_beat(0, 1'b1, 10'h010, 20'd111);
        queue_beat(0, 1'b1, 10'h011, 20'd222);
        queue_beat(0, 1'b0, 10'h010, 20'd0);
        queue_beat(0, 1'b0, 10'h011, 20'd0);
        queue_beat(1, 1'b0, 10'h032, 20'd0);
        run_traffic(40);
        exp_log = '{0, 0, 0, 0, 1};
        total++;
        if (!logs_equal(ready_log, exp_log)) begin
            bad++;
            $display("FAIL burst_lock: ready order %s required %s", log_str(ready_log), log_str(exp_log));
        end
    endtask

    task automatic test_fairness();
        int exp_log[$];
        apply_reset();
        for (int i = 0; i < 20; i++) queue_beat(0, 1'b1, 10'h100 + 10'(i), 20'd1000 + 20'(i));
        queue_beat(1, 1'b1, 10'h200, 20'd4242);
        run_traffic(80);
        for (int i = 0; i < 8; i++)  exp_log.push_back(0);
        exp_log.push_back(1);
        for (int i = 0; i < 12; i++) exp_log.push_back(0);
        total++;
        if (!logs_equal(ready_log, exp_log)) begin
            bad++;
            $display("FAIL max_beats: ready order %s required %s", log_str(ready_log), log_str(exp_log));
        end
        total++;
        if ({r_mem0[10'h113], r_mem0[10'h200]} !== {20'd1019, 20'd4242}) begin
            bad++;
            $display("FAIL max_beats_ram: RAM[113]=%0d RAM[200]=%0d required 1019 4242",
                     r_mem0[10'h113], r_mem0[10'h200]);
        end
    endtask

    task automatic test_read_lat1();
        bit           got = 1'b0;
        int           rdy_cyc[$];
        int           exp_cyc[$];
        bit           we_seen = 1'b0;
        beat_t        e;
        apply_reset();
        @(posedge clk); #1;
        bus1.r0_req = 1'b1; bus1.r0_rw = 1'b1; bus1.r0_addr = 10'h046; bus1.r0_wdata = 20'd777;
        for (int n = 0; n < 10 && !got; n++) begin
            @(negedge clk);
            if (bus1.r0_ready) got = 1'b1;
            else begin @(posedge clk); #1; end
        end
        @(posedge clk); #1;
        bus1.r0_req = 1'b0;
        total++;
        if (!got) begin
            bad++;
            $display("FAIL lat1_preload: r0 write ready=0 required 1 within 10 cycles");
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            e.rw = 1'b0; e.addr = 10'h046; e.data = 20'd777;
            e1.push_back(e);
        end
        bus1.r1_req = 1'b1; bus1.r1_rw = 1'b0; bus1.r1_addr = 10'h046;
        for (int c = 0; c < 10 && e1.size() > 0; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            @(negedge clk);
            we_seen |= bus1.ram_we;
            if (c == 1) begin
                total++;
                if ({bus1.gnt, bus1.r1_ready, bus1.ram_addr} !== {2'b10, 1'b0, 10'h046}) begin
                    bad++;
                    $display("FAIL lat1_own_cycle: gnt=%b ready=%b addr=%h required 10 0 046",
                             bus1.gnt, bus1.r1_ready, bus1.ram_addr);
                end
            end
            if (bus1.r1_ready) begin
                rdy_cyc.push_back(c);
                e = e1.pop_front();
                total++;
                if (bus1.r1_rdata !== e.data) begin
                    bad++;
                    $display("FAIL lat1_rdata: rdata=%0d required %0d", bus1.r1_rdata, e.data);
                end
            end
        end
        @(posedge clk); #1;
        bus1.r1_req = 1'b0;
        e1.delete();
        exp_cyc = '{2, 4};
        total++;
        if (!logs_equal(rdy_cyc, exp_cyc)) begin
            bad++;
            $display("FAIL lat1_timing: ready cycles %s required %s", log_str(rdy_cyc), log_str(exp_cyc));
        end
        total++;
        if (we_seen !== 1'b0) begin
            bad++;
            $display("FAIL lat1_we: ram_we seen=%b required 0", we_seen);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midbeat();
        int exp_log[$];
        apply_reset();
        @(posedge clk); #1;
        bus0.r0_req = 1'b1; bus0.r0_rw = 1'b1; bus0.r0_addr = 10'h077; bus0.r0_wdata = 20'd555;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (bus0.r0_ready !== 1'b0) begin
            bad++;
            $display("FAIL midbeat_ready: r0_ready=%b required 0 while reset abandons beat", bus0.r0_ready);
        end
        @(negedge clk);
        total++;
        if ({bus0.gnt, bus0.ram_we, bus0.r0_ready} !== 4'b0000) begin
            bad++;
            $display("FAIL midbeat_after_edge: gnt=%b we=%b ready=%b required 00 0 0",
                     bus0.gnt, bus0.ram_we, bus0.r0_ready);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        clear_inputs();
        queue_beat(0, 1'b1, 10'h077, 20'd556);
        queue_beat(1, 1'b1, 10'h078, 20'd557);
        run_traffic(30);
        exp_log = '{0, 1};
        total++;
        if (!logs_equal(ready_log, exp_log)) begin
            bad++;
            $display("FAIL midbeat_tie: ready order %s required %s", log_str(ready_log), log_str(exp_log));
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_write();
        test_tie_release();
        test_burst_lock();
        test_fairness();
        test_read_lat1();
        test_reset_midbeat();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mem_port_arbiter
`default_nettype wire
